uart_frame_rx: RTL and testbench
================================

Name: uart_frame_rx

Overview:
- Host-side receive path: consumes the byte stream produced by the existing UART receiver (`received` strobe plus `rx_byte`).
- Parses framed command packets and writes each payload byte into the program/data memory of the compute block.
- Issues a single-cycle start pulse when a frame arrives intact.
- Complements the existing result path: the host sends a program in, the block runs, and the existing logic transmits the result byte back.

Parameters:
- SYNC_BYTE, 8'hA5, frame start marker.
- MAX_LEN, 16, maximum payload length in bytes; must be ≤ 2**ADDR_W.
- ADDR_W, 4, width of wr_addr.
- TIMEOUT_CYCLES, 120000, idle clocks allowed between bytes inside a frame (10 ms at 12 MHz).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- rx_valid  in  1  single-cycle strobe, byte available on rx_data.
- rx_data  in  8  received byte.
- rx_error  in  1  single-cycle UART framing-error strobe.
- wr_en  out  1  payload write strobe.
- wr_addr  out  ADDR_W  payload byte index, starting at 0 in each frame.
- wr_data  out  8  payload byte.
- frame_ok  out  1  single-cycle pulse; frame accepted, acts as run start.
- frame_err  out  1  single-cycle pulse; frame aborted.
- err_code  out  2  cause of the last abort (0 none, 1 bad length, 2 checksum, 3 timeout or UART error); held until the next SYNC is accepted.
- busy  out  1  high while a frame is in progress (any state other than IDLE).
- frame_len  out  8  length of the last accepted frame; updated with frame_ok.

Behaviour:
- Frame format: SYNC, LEN, LEN payload bytes, CSUM.
  - CSUM is the XOR of LEN and all payload bytes.
- Reset (asynchronous, any time, including mid-frame):
  - State returns to IDLE.
  - All outputs go to 0; err_code = 0; frame_len = 0.
  - Counters clear. Any partial frame is abandoned and no pulse is emitted.
- All outputs are registered.
- States and transitions:
  - IDLE: rx_valid with rx_data == SYNC_BYTE → LEN state; clear err_code, running XOR, and index. Other bytes and rx_error are ignored silently.
  - LEN: rx_valid → if byte is 0 or > MAX_LEN, abort with code 1. Otherwise latch the length, XOR = byte, go to PAYLOAD.
  - PAYLOAD: each rx_valid → next cycle wr_en=1, wr_addr=index, wr_data=byte; XOR ^= byte; index++. After the LEN-th byte, go to CSUM.
  - CSUM: rx_valid → if byte == XOR, frame_ok=1 and frame_len=LEN on the next cycle. Otherwise abort with code 2. Either way return to IDLE.
- Abort:
  - frame_err=1 for one cycle and err_code is set, both registered one cycle after the triggering event.
  - Return to IDLE.
  - frame_ok is never asserted for an aborted frame.
- Eager writes: payload is written before the checksum is verified. After frame_err, memory contents are undefined and consumers must wait for frame_ok.
- Timeout:
  - In LEN, PAYLOAD, or CSUM, a counter clears on every rx_valid and increments otherwise.
  - When it reaches TIMEOUT_CYCLES, abort with code 3.
- rx_error in any non-IDLE state aborts with code 3.
- Simultaneous events (same cycle):
  - rx_error with rx_valid: error wins and the byte is discarded.
  - Timeout terminal count with rx_valid: the byte wins and the counter clears.
- Latency: rx_valid to wr_en, frame_ok, or frame_err is exactly 1 cycle. Back-to-back rx_valid on consecutive cycles is supported.
- A SYNC value inside a frame is treated as ordinary data; there is no resynchronisation mid-frame.
- busy rises the cycle after SYNC is accepted and falls in the same cycle that frame_ok or frame_err pulses.

Test Plan:
- Good frame: bytes A5 03 11 22 33 03 → three wr_en pulses at addr 0/1/2 with data 11/22/33; frame_ok pulses 1 cycle after the last byte; frame_len=3; err_code=0; busy falls.
- Bad checksum: A5 02 10 20 00 → two writes, then frame_err with err_code=2; no frame_ok. A following good frame clears err_code to 0.
- Bad length: A5 00 and A5 11 (17 > MAX_LEN) → frame_err, err_code=1, no wr_en; the next bytes are ignored until A5.
- Timeout: A5 02 44, then silence for TIMEOUT_CYCLES → frame_err, err_code=3 exactly TIMEOUT_CYCLES+1 cycles after the last rx_valid; a gap of TIMEOUT_CYCLES−1 followed by a byte does not abort.
- Errors and noise:
  - rx_error coincident with the second payload byte → abort with code 3 and only one write.
  - Leading garbage 00 FF 5A before A5 → ignored.
- Async reset asserted mid-PAYLOAD between clock edges → outputs 0 immediately; no pulse after release; a fresh frame is then accepted with addresses starting at 0.

Source files
------------

// File: rtl/uart_frame_rx.sv
// rtl/uart_frame_rx.sv - framed command receiver: SYNC, LEN, payload, XOR checksum into memory writes
// Payload bytes are written as they arrive; consumers must wait for frame_ok before using memory.
module uart_frame_rx #(
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter int         MAX_LEN        = 16,
  parameter int         ADDR_W         = 4,
  parameter int         TIMEOUT_CYCLES = 120000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  input  logic              rx_error,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              frame_ok,
  output logic              frame_err,
  output logic [1:0]        err_code,
  output logic              busy,
  output logic [7:0]        frame_len
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [8:0]    MAX_LEN_W = 9'(MAX_LEN);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] ERR_LEN  = 2'd1;
  localparam logic [1:0] ERR_CSUM = 2'd2;
  localparam logic [1:0] ERR_LINK = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_LEN, S_PAYLOAD, S_CSUM} state_t;

  state_t            state;
  logic [7:0]        len_q;
  logic [7:0]        xor_q;
  logic [ADDR_W-1:0] idx;
  logic [TW-1:0]     tcnt;
  logic [ADDR_W-1:0] last_idx;

  // len_q never exceeds 2**ADDR_W, so len_q-1 always fits the index width
  assign last_idx = ADDR_W'(len_q - 8'd1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      len_q     <= '0;
      xor_q     <= '0;
      idx       <= '0;
      tcnt      <= '0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      err_code  <= '0;
      busy      <= 1'b0;
      frame_len <= '0;
    end else begin
      wr_en     <= 1'b0;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      if (state == S_IDLE) begin
        if (rx_valid && rx_data == SYNC_BYTE) begin
          state    <= S_LEN;
          busy     <= 1'b1;
          err_code <= '0;
          xor_q    <= '0;
          idx      <= '0;
          tcnt     <= '0;
        end
      end else if (rx_error) begin
        // a line error wins over a byte arriving in the same cycle
        state     <= S_IDLE;
        busy      <= 1'b0;
        frame_err <= 1'b1;
        err_code  <= ERR_LINK;
      end else if (rx_valid) begin
        tcnt <= '0;
        case (state)
          S_LEN: begin
            if (rx_data == 8'd0 || {1'b0, rx_data} > MAX_LEN_W) begin
              state     <= S_IDLE;
              busy      <= 1'b0;
              frame_err <= 1'b1;
              err_code  <= ERR_LEN;
            end else begin
              len_q <= rx_data;
              xor_q <= rx_data;
              state <= S_PAYLOAD;
            end
          end
          S_PAYLOAD: begin
            wr_en   <= 1'b1;
            wr_addr <= idx;
            wr_data <= rx_data;
            xor_q   <= xor_q ^ rx_data;
            idx     <= idx + 1'b1;
            if (idx == last_idx) state <= S_CSUM;
          end
          S_CSUM: begin
            state <= S_IDLE;
            busy  <= 1'b0;
            if (rx_data == xor_q) begin
              frame_ok  <= 1'b1;
              frame_len <= len_q;
            end else begin
              frame_err <= 1'b1;
              err_code  <= ERR_CSUM;
            end
          end
          default: state <= S_IDLE;
        endcase
      end else if (tcnt == TMO_LAST) begin
        // this idle cycle would bring the count to TIMEOUT_CYCLES
        state     <= S_IDLE;
        busy      <= 1'b0;
        frame_err <= 1'b1;
        err_code  <= ERR_LINK;
      end else begin
        tcnt <= tcnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_frame_rx.sv
// tb/tb_uart_frame_rx.sv - scoreboard bench for uart_frame_rx
// Expected output events are queued with their due cycle as bytes are driven.
module tb_uart_frame_rx;

  localparam int T = 40;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_error;
  logic       wr_en;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic       frame_ok;
  logic       frame_err;
  logic [1:0] err_code;
  logic       busy;
  logic [7:0] frame_len;

  uart_frame_rx #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data), .rx_error(rx_error),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .frame_ok(frame_ok),
    .frame_err(frame_err), .err_code(err_code), .busy(busy), .frame_len(frame_len)
  );

  always #5 clk = ~clk;

  typedef struct {int kind; int a; int d; int due;} ev_t;  // kind: 0 write, 1 ok, 2 err
  ev_t q[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  int mst = 0;  // reference model: 0 idle, 1 len, 2 payload, 3 csum
  int mlen, mx, midx;
  int last_cyc;

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic push_ev(input int kind, input int a, input int d, input int due);
    ev_t e;
    e.kind = kind; e.a = a; e.d = d; e.due = due;
    q.push_back(e);
  endtask

  task automatic model_byte(input int b);
    case (mst)
      0: if (b == 8'hA5) mst = 1;
      1: begin
        if (b == 0 || b > 16) begin
          push_ev(2, 0, 1, cyc + 1);
          mst = 0;
        end else begin
          mlen = b; mx = b; midx = 0; mst = 2;
        end
      end
      2: begin
        push_ev(0, midx, b, cyc + 1);
        mx = mx ^ b;
        midx++;
        if (midx == mlen) mst = 3;
      end
      default: begin
        if (b == mx) push_ev(1, mlen, 0, cyc + 1);
        else         push_ev(2, 0, 2, cyc + 1);
        mst = 0;
      end
    endcase
  endtask

  task automatic send(input int b);
    model_byte(b);
    last_cyc = cyc;
    rx_valid = 1'b1;
    rx_data  = 8'(b);
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_with_error(input int b);
    if (mst != 0) push_ev(2, 0, 3, cyc + 1);
    mst = 0;
    rx_valid = 1'b1;
    rx_error = 1'b1;
    rx_data  = 8'(b);
    @(negedge clk);
    rx_valid = 1'b0;
    rx_error = 1'b0;
  endtask

  task automatic random_frame();
    int n, x, b;
    n = $urandom_range(1, 16);
    send(8'hA5);
    send(n);
    x = n;
    for (int i = 0; i < n; i++) begin
      b = $urandom_range(0, 255);
      x = x ^ b;
      send(b);
    end
    send(x);
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (wr_en || frame_ok || frame_err) begin
        if (q.size() == 0) begin
          check("spurious_event", {29'd0, frame_err, frame_ok, wr_en}, 32'd0);
        end else begin
          ev_t e;
          e = q.pop_front();
          check("event_cycle", cyc, e.due);
          check("event_kind", {29'd0, frame_err, frame_ok, wr_en}, 32'd1 << e.kind);
          if (e.kind == 0) begin
            check("wr_addr", wr_addr, e.a);
            check("wr_data", wr_data, e.d);
            check("busy_in_frame", busy, 1);
          end else if (e.kind == 1) begin
            check("frame_len", frame_len, e.a);
            check("err_code_ok", err_code, 0);
            check("busy_after_ok", busy, 0);
          end else begin
            check("err_code", err_code, e.d);
            check("busy_after_err", busy, 0);
          end
        end
      end else if (q.size() > 0 && q[0].due < cyc) begin
        check("missing_event", cyc, q[0].due);
        void'(q.pop_front());
      end
    end
  end

  initial begin
    reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; rx_error = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_wr_en", wr_en, 0);
    check("rst_frame_ok", frame_ok, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_err_code", err_code, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_len", frame_len, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // leading garbage, then a good frame
    send(8'h00); send(8'hFF); send(8'h5A);
    check("idle_not_busy", busy, 0);
    send(8'hA5);
    check("busy_rise", busy, 1);
    send(8'h03); send(8'h11); send(8'h22); send(8'h33); send(8'h03);
    repeat (2) @(negedge clk);

    // bad checksum, error code held, then a good frame clears it
    send(8'hA5); send(8'h02); send(8'h10); send(8'h20); send(8'h00);
    repeat (3) @(negedge clk);
    check("err_hold", err_code, 2);
    send(8'hA5); send(8'h01); send(8'hA5); send(8'h01 ^ 8'hA5);
    repeat (2) @(negedge clk);

    // bad lengths; trailing bytes ignored until SYNC
    send(8'hA5); send(8'h00); send(8'h01); send(8'h02);
    send(8'hA5); send(8'h11); send(8'h03);
    repeat (2) @(negedge clk);
    check("len_err_hold", err_code, 1);
    send(8'hA5); send(8'h10);
    for (int i = 0; i < 16; i++) send(i);
    send(8'h10);

    // timeout after silence
    send(8'hA5); send(8'h02); send(8'h44);
    push_ev(2, 0, 3, last_cyc + T + 1);
    mst = 0;
    repeat (T + 5) @(negedge clk);

    // gap of T-1 idle cycles does not abort
    send(8'hA5); send(8'h02); send(8'h44);
    repeat (T - 1) @(negedge clk);
    send(8'h55); send(8'h02 ^ 8'h44 ^ 8'h55);
    repeat (2) @(negedge clk);

    // line error with the second payload byte
    send(8'hA5); send(8'h03); send(8'h01);
    send_with_error(8'h02);
    send(8'h03);
    repeat (2) @(negedge clk);
    send_with_error(8'h00);
    repeat (2) @(negedge clk);

    // back-to-back random frames
    for (int k = 0; k < 4; k++) random_frame();
    repeat (3) @(negedge clk);

    // asynchronous reset in the middle of a payload
    send(8'hA5); send(8'h04); send(8'h01); send(8'h02);
    #2;
    reset = 1'b1;
    q.delete();
    mst = 0;
    #1;
    check("async_wr_en", wr_en, 0);
    check("async_wr_addr", wr_addr, 0);
    check("async_wr_data", wr_data, 0);
    check("async_busy", busy, 0);
    check("async_frame_len", frame_len, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    send(8'hA5); send(8'h02); send(8'h7E); send(8'h81); send(8'h02 ^ 8'h7E ^ 8'h81);
    repeat (4) @(negedge clk);

    check("queue_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
